// File: rtl/led_pkg.sv
// Shared definitions for the LED indicator controller: mode encodings and
// the per-channel state enumeration.
package led_pkg;

    // Width of one channel's mode field.
    localparam int MODE_W = 2;

    // Mode encodings as seen on each channel's field of the mode bus.
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    // Per-channel FSM states.
    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_ON         = 3'd1,
        ST_BLINK      = 3'd2,
        ST_BURST_WAIT = 3'd3,
        ST_BURST_HI   = 3'd4,
        ST_BURST_LO   = 3'd5,
        ST_DONE       = 3'd6
    } ch_state_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode-driven FSM with steady, blink and counted-burst
// behaviour. Outputs are registered from the next state so the LED follows
// the effective mode one clock later.
module led_channel
    import led_pkg::*;
#(
    parameter int BURST_N = 3
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       tick,
    input  logic       phase_next,
    output logic       led,
    output logic       burst_done
);

    localparam int             PW         = $clog2(BURST_N + 1);
    localparam logic [PW-1:0]  PULSE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]  PULSE_ONE  = PW'(1);
    localparam logic [PW-1:0]  PULSE_LAST = PW'(BURST_N);

    ch_state_e      state_r;
    ch_state_e      state_next_s;
    logic [PW-1:0]  pulse_cnt_r;
    logic [PW-1:0]  pulse_cnt_next_s;
    logic           led_r;
    logic           led_next_s;
    logic           done_r;
    logic           done_next_s;

    // State, pulse counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_OFF;
            pulse_cnt_r <= PULSE_ZERO;
            led_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pulse_cnt_r <= pulse_cnt_next_s;
            led_r       <= led_next_s;
            done_r      <= done_next_s;
        end
    end

    // Next-state and pulse-count logic; leaving burst mode always clears the count.
    always_comb begin
        state_next_s     = state_r;
        pulse_cnt_next_s = pulse_cnt_r;
        case (mode)
            MODE_OFF: begin
                state_next_s     = ST_OFF;
                pulse_cnt_next_s = PULSE_ZERO;
            end
            MODE_ON: begin
                state_next_s     = ST_ON;
                pulse_cnt_next_s = PULSE_ZERO;
            end
            MODE_BLINK: begin
                state_next_s     = ST_BLINK;
                pulse_cnt_next_s = PULSE_ZERO;
            end
            MODE_BURST: begin
                case (state_r)
                    ST_OFF, ST_ON, ST_BLINK: begin
                        state_next_s     = ST_BURST_WAIT;
                        pulse_cnt_next_s = PULSE_ZERO;
                    end
                    ST_BURST_WAIT: begin
                        if (tick) begin
                            state_next_s = ST_BURST_HI;
                        end else begin
                            state_next_s = ST_BURST_WAIT;
                        end
                    end
                    ST_BURST_HI: begin
                        if (tick) begin
                            state_next_s     = ST_BURST_LO;
                            pulse_cnt_next_s = pulse_cnt_r + PULSE_ONE;
                        end else begin
                            state_next_s = ST_BURST_HI;
                        end
                    end
                    ST_BURST_LO: begin
                        if (tick) begin
                            if (pulse_cnt_r == PULSE_LAST) begin
                                state_next_s = ST_DONE;
                            end else begin
                                state_next_s = ST_BURST_HI;
                            end
                        end else begin
                            state_next_s = ST_BURST_LO;
                        end
                    end
                    ST_DONE: begin
                        state_next_s = ST_DONE;
                    end
                    default: begin
                        state_next_s     = ST_OFF;
                        pulse_cnt_next_s = PULSE_ZERO;
                    end
                endcase
            end
            default: begin
                state_next_s     = ST_OFF;
                pulse_cnt_next_s = PULSE_ZERO;
            end
        endcase
    end

    // Output decode from the next state; blink uses the upcoming phase so all
    // blinking channels match the shared phase register exactly.
    always_comb begin
        led_next_s  = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_ON:       led_next_s  = 1'b1;
            ST_BLINK:    led_next_s  = phase_next;
            ST_BURST_HI: led_next_s  = 1'b1;
            ST_DONE:     done_next_s = 1'b1;
            default: begin
                led_next_s  = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    assign led        = led_r;
    assign burst_done = done_r;

endmodule

// File: rtl/led_indicator_ctrl.sv
// Multi-channel LED indicator controller. Holds the shared half-period
// counter and blink phase, and instantiates one led_channel per LED.
// Optional build macro LED_SYNC_EN: passes the mode bus through a 2-flop
// synchroniser (3-cycle mode-to-led latency instead of 1).
module led_indicator_ctrl
    import led_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int HALF_PERIOD = 1000000,
    parameter int BURST_N     = 3
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [MODE_W*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]        led,
    output logic [NUM_CH-1:0]        burst_done
);

    localparam int            CW       = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(HALF_PERIOD - 1);

    logic [CW-1:0]              cnt_r;
    logic                       phase_r;
    logic                       tick_s;
    logic                       phase_next_s;
    logic [MODE_W*NUM_CH-1:0]   mode_eff_s;

    assign tick_s       = (cnt_r == CNT_MAX);
    assign phase_next_s = phase_r ^ tick_s;

    // Shared half-period counter and blink phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            phase_r <= 1'b0;
        end else begin
            if (tick_s) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            phase_r <= phase_next_s;
        end
    end

`ifdef LED_SYNC_EN
    logic [MODE_W*NUM_CH-1:0] mode_sync1_r;
    logic [MODE_W*NUM_CH-1:0] mode_sync2_r;

    // Two-flop synchroniser on every mode bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sync1_r <= {(MODE_W*NUM_CH){1'b0}};
            mode_sync2_r <= {(MODE_W*NUM_CH){1'b0}};
        end else begin
            mode_sync1_r <= mode;
            mode_sync2_r <= mode_sync1_r;
        end
    end

    assign mode_eff_s = mode_sync2_r;
`else
    assign mode_eff_s = mode;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_channel #(
            .BURST_N (BURST_N)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .mode       (mode_eff_s[MODE_W*i +: MODE_W]),
            .tick       (tick_s),
            .phase_next (phase_next_s),
            .led        (led[i]),
            .burst_done (burst_done[i])
        );
    end

endmodule

// File: tb/tb_led_indicator_ctrl.sv
// Self-checking bench for led_indicator_ctrl with HALF_PERIOD=4, BURST_N=3,
// NUM_CH=2. Steady modes are table-driven; blink, burst, abort and reset
// corner cases are hand-written sequences.
module tb_led_indicator_ctrl;

    localparam int NUM_CH = 2;
    localparam int HP     = 4;
    localparam int BN     = 3;
`ifdef LED_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [3:0] mode;
        logic [1:0] exp_led;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        mode = 4'hF;
    logic [1:0]        led;
    logic [1:0]        burst_done;

    int passed = 0;
    int total  = 0;
    int n_edges = 0;

    vec_t vecs [5];

    always #5 clk = ~clk;

    led_indicator_ctrl #(
        .NUM_CH      (NUM_CH),
        .HALF_PERIOD (HP),
        .BURST_N     (BN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .led        (led),
        .burst_done (burst_done)
    );

    // Advance one clock; n_edges counts edges since reset release.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) n_edges = 0;
        else        n_edges = n_edges + 1;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, n_edges);
        end
    endtask

    // Wait for burst start on ch0, then check the full 3-pulse pattern and DONE.
    task automatic check_burst(input string nm);
        bit   seen;
        logic e;
        seen = 1'b0;
        for (int w = 0; w < LAT + 6 && !seen; w++) begin
            cyc();
            if (led[0] === 1'b1) seen = 1'b1;
        end
        chk({nm, "_rise"}, 32'(seen), 32'd1);
        if (!seen) return;
        chk({nm, "_align"}, 32'(n_edges % HP), 32'd0);
        for (int k = 0; k < 24; k++) begin
            e = (k < 20) && (((k / 4) % 2) == 0);
            chk({nm, "_pulse"}, 32'({burst_done, led}), 32'({3'b000, e}));
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            chk({nm, "_done"}, 32'({burst_done, led}), 32'h4);
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] prev;
        logic       p;
        bit         seen;

        vecs[0] = '{mode: 4'b0001, exp_led: 2'b01};
        vecs[1] = '{mode: 4'b0100, exp_led: 2'b10};
        vecs[2] = '{mode: 4'b0101, exp_led: 2'b11};
        vecs[3] = '{mode: 4'b0000, exp_led: 2'b00};
        vecs[4] = '{mode: 4'b0001, exp_led: 2'b01};

        // Reset held with all channels requesting burst.
        rst_n = 1'b0;
        mode  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("reset", 32'({burst_done, led}), 32'h0);
        end
        rst_n = 1'b1;
        mode  = 4'h0;
        cyc();
        chk("post_reset_off", 32'({burst_done, led}), 32'h0);

        // Steady OFF/ON patterns with latency check.
        prev = 2'b00;
        for (int v = 0; v < 5; v++) begin
            mode = vecs[v].mode;
            for (int c = 1; c <= LAT + 3; c++) begin
                cyc();
                if (c < LAT) chk("steady_latency", 32'({burst_done, led}), 32'({2'b00, prev}));
                else         chk("steady", 32'({burst_done, led}), 32'({2'b00, vecs[v].exp_led}));
            end
            prev = vecs[v].exp_led;
        end

        // Both channels blink in phase with the shared phase bit.
        mode = 4'b1010;
        repeat (LAT) cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            p = 1'((n_edges / HP) % 2);
            chk("blink", 32'({burst_done, led}), 32'({2'b00, p, p}));
        end

        // First burst from OFF.
        mode = 4'b0000;
        repeat (LAT + 1) cyc();
        mode = 4'b0011;
        check_burst("burst1");

        // One cycle away from burst mode re-arms it.
        mode = 4'b0000;
        cyc();
        mode = 4'b0011;
        repeat (LAT - 1) cyc();
        chk("rearm_done_clear", 32'(burst_done[0]), 32'd0);
        check_burst("burst2");

        // Abort during the second pulse by switching to ON.
        mode = 4'b0000;
        cyc();
        mode = 4'b0011;
        seen = 1'b0;
        for (int w = 0; w < LAT + 6 && !seen; w++) begin
            cyc();
            if (led[0] === 1'b1) seen = 1'b1;
        end
        chk("abort_rise", 32'(seen), 32'd1);
        repeat (8) cyc();
        chk("abort_pulse2", 32'({burst_done, led}), 32'h1);
        cyc();
        mode = 4'b0001;
        repeat (LAT) cyc();
        chk("abort_on", 32'({burst_done, led}), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_hold", 32'({burst_done, led}), 32'h1);
        end

        // Reset mid-burst, then a fresh burst after release.
        mode = 4'b0011;
        seen = 1'b0;
        for (int w = 0; w < LAT + 6 && !seen; w++) begin
            cyc();
            if (led[0] === 1'b1) seen = 1'b1;
        end
        chk("rst_burst_rise", 32'(seen), 32'd1);
        repeat (2) cyc();
        rst_n = 1'b0;
        cyc();
        chk("rst_mid", 32'({burst_done, led}), 32'h0);
        cyc();
        chk("rst_mid", 32'({burst_done, led}), 32'h0);
        rst_n = 1'b1;
        check_burst("burst_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
